// File: rtl/spr_wr_sched_pkg.sv
// Shared types and helpers for the SPR write-port scheduler.
// Holds the FSM encoding, default widths and the saturating commit counter.
package spr_wr_sched_pkg;

  localparam int unsigned SprAddrW = 10;
  localparam int unsigned SprDataW = 32;
  localparam int unsigned SprIdxW  = 5;
  localparam int unsigned CntW     = 16;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDrain = 2'd1,
    StIdle  = 2'd2
  } state_e;

  function automatic logic [CntW-1:0] sat_add(input logic [CntW-1:0] cnt,
                                              input logic [1:0]      inc);
    logic [CntW:0] sum;
    sum = {1'b0, cnt} + {{(CntW - 1){1'b0}}, inc};
    return sum[CntW] ? '1 : sum[CntW-1:0];
  endfunction

endpackage

// File: rtl/spr_wr_sched_if.sv
// Request, SPR write-port and hazard-check bundle of the scheduler.
// master = requester/pipeline side, slave = scheduler side.
interface spr_wr_sched_if
  import spr_wr_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned AW    = SprAddrW,
  parameter int unsigned DW    = SprDataW
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_data;
  logic                wr0;
  logic                wr1;
  logic [AW-1:0]       waddr0;
  logic [AW-1:0]       waddr1;
  logic [DW-1:0]       wd0;
  logic [DW-1:0]       wd1;
  logic [AW-1:0]       chk_addr0;
  logic [AW-1:0]       chk_addr1;
  logic                chk_hit0;
  logic                chk_hit1;

  modport master (
    output req_valid, req_addr, req_data, chk_addr0, chk_addr1,
    input  req_ready, wr0, wr1, waddr0, waddr1, wd0, wd1, chk_hit0, chk_hit1
  );

  modport slave (
    input  req_valid, req_addr, req_data, chk_addr0, chk_addr1,
    output req_ready, wr0, wr1, waddr0, waddr1, wd0, wd1, chk_hit0, chk_hit1
  );
endinterface

// File: rtl/spr_wr_sched_rr_pick2.sv
// Rotating two-winner picker: first valid from ptr_i wins port0, the next valid
// requester with a different SPR index wins port1.
module spr_wr_sched_rr_pick2 #(
  parameter int unsigned NReq = 4,
  parameter int unsigned IdxW = 5,
  parameter int unsigned PtrW = 2
) (
  input  logic            en_i,
  input  logic [NReq-1:0] valid_i,
  input  logic [IdxW-1:0] idx_i [NReq],
  input  logic [PtrW-1:0] ptr_i,
  output logic [NReq-1:0] gnt0_o,
  output logic [NReq-1:0] gnt1_o,
  output logic            g0_vld_o,
  output logic            g1_vld_o,
  output logic [PtrW-1:0] g0_idx_o,
  output logic [PtrW-1:0] g1_idx_o,
  output logic [PtrW-1:0] last_o
);

  localparam logic [PtrW:0] NReqW = (PtrW + 1)'(NReq);

  always_comb begin
    logic [PtrW:0]   pos_w;
    logic [PtrW-1:0] pos;
    logic [IdxW-1:0] idx0;
    gnt0_o   = '0;
    gnt1_o   = '0;
    g0_vld_o = 1'b0;
    g1_vld_o = 1'b0;
    g0_idx_o = '0;
    g1_idx_o = '0;
    idx0     = '0;
    pos_w    = '0;
    pos      = '0;
    for (int unsigned k = 0; k < NReq; k++) begin
      pos_w = {1'b0, ptr_i} + (PtrW + 1)'(k);
      if (pos_w >= NReqW) pos_w = pos_w - NReqW;
      pos = pos_w[PtrW-1:0];
      if (en_i && valid_i[pos]) begin
        if (!g0_vld_o) begin
          g0_vld_o    = 1'b1;
          gnt0_o[pos] = 1'b1;
          g0_idx_o    = pos;
          idx0        = idx_i[pos];
        end else if (!g1_vld_o && (idx_i[pos] != idx0)) begin
          g1_vld_o    = 1'b1;
          gnt1_o[pos] = 1'b1;
          g1_idx_o    = pos;
        end
      end
    end
    // port1 always sits later in the rotation than port0
    last_o = g1_vld_o ? g1_idx_o : g0_idx_o;
  end

endmodule

// File: rtl/spr_wr_sched.sv
// Round-robin scheduler for the two SPR write ports with same-index exclusion,
// registered write outputs, RAW hazard flags and a quiesce/drain FSM.
module spr_wr_sched
  import spr_wr_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned AW    = SprAddrW,
  parameter int unsigned DW    = SprDataW,
  parameter int unsigned IDX_W = SprIdxW
) (
  input  logic            clk,
  input  logic            rst_n,
  spr_wr_sched_if.slave   bus,
  input  logic            quiesce,
  output logic            idle,
  output logic [CntW-1:0] wr_cnt
);

  localparam int unsigned PtrW = $clog2(N_REQ);

  state_e          state_q, state_d;
  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
  logic            wr0_q, wr0_d, wr1_q, wr1_d;
  logic [AW-1:0]   waddr0_q, waddr0_d, waddr1_q, waddr1_d;
  logic [DW-1:0]   wd0_q, wd0_d, wd1_q, wd1_d;
  logic [CntW-1:0] wr_cnt_q, wr_cnt_d;

  logic [AW-1:0]    addr_arr [N_REQ];
  logic [DW-1:0]    data_arr [N_REQ];
  logic [IDX_W-1:0] idx_arr  [N_REQ];
  logic [N_REQ-1:0] vhit0, vhit1;
  logic [IDX_W-1:0] chk_idx0, chk_idx1;

  assign chk_idx0 = bus.chk_addr0[IDX_W-1:0];
  assign chk_idx1 = bus.chk_addr1[IDX_W-1:0];

  for (genvar i = 0; i < N_REQ; i++) begin : g_req
    assign addr_arr[i] = bus.req_addr[i*AW +: AW];
    assign data_arr[i] = bus.req_data[i*DW +: DW];
    assign idx_arr[i]  = addr_arr[i][IDX_W-1:0];
    assign vhit0[i]    = bus.req_valid[i] && (idx_arr[i] == chk_idx0);
    assign vhit1[i]    = bus.req_valid[i] && (idx_arr[i] == chk_idx1);
  end

  logic            grant_en;
  logic [N_REQ-1:0] gnt0, gnt1;
  logic            g0_vld, g1_vld;
  logic [PtrW-1:0] g0_idx, g1_idx, last_idx;

  // The cycle quiesce is first seen already gets no grant.
  assign grant_en = (state_q == StRun) && !quiesce;

  spr_wr_sched_rr_pick2 #(
    .NReq (N_REQ),
    .IdxW (IDX_W),
    .PtrW (PtrW)
  ) u_pick (
    .en_i     (grant_en),
    .valid_i  (bus.req_valid),
    .idx_i    (idx_arr),
    .ptr_i    (rr_ptr_q),
    .gnt0_o   (gnt0),
    .gnt1_o   (gnt1),
    .g0_vld_o (g0_vld),
    .g1_vld_o (g1_vld),
    .g0_idx_o (g0_idx),
    .g1_idx_o (g1_idx),
    .last_o   (last_idx)
  );

  assign bus.req_ready = gnt0 | gnt1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (quiesce) state_d = StDrain;
      StDrain: if (!wr0_q && !wr1_q) state_d = StIdle;
      StIdle:  if (!quiesce) state_d = StRun;
      default: state_d = StRun;
    endcase

    rr_ptr_d = rr_ptr_q;
    if (g0_vld) begin
      rr_ptr_d = (last_idx == PtrW'(N_REQ - 1)) ? '0 : last_idx + PtrW'(1);
    end

    wr0_d    = g0_vld;
    waddr0_d = g0_vld ? addr_arr[g0_idx] : '0;
    wd0_d    = g0_vld ? data_arr[g0_idx] : '0;
    wr1_d    = g1_vld;
    waddr1_d = g1_vld ? addr_arr[g1_idx] : '0;
    wd1_d    = g1_vld ? data_arr[g1_idx] : '0;

    wr_cnt_d = sat_add(wr_cnt_q, {1'b0, wr0_q} + {1'b0, wr1_q});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StRun;
      rr_ptr_q <= '0;
      wr0_q    <= 1'b0;
      wr1_q    <= 1'b0;
      waddr0_q <= '0;
      waddr1_q <= '0;
      wd0_q    <= '0;
      wd1_q    <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      wr0_q    <= wr0_d;
      wr1_q    <= wr1_d;
      waddr0_q <= waddr0_d;
      waddr1_q <= waddr1_d;
      wd0_q    <= wd0_d;
      wd1_q    <= wd1_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign bus.chk_hit0 = (|vhit0) || (wr0_q && (waddr0_q[IDX_W-1:0] == chk_idx0))
                                 || (wr1_q && (waddr1_q[IDX_W-1:0] == chk_idx0));
  assign bus.chk_hit1 = (|vhit1) || (wr0_q && (waddr0_q[IDX_W-1:0] == chk_idx1))
                                 || (wr1_q && (waddr1_q[IDX_W-1:0] == chk_idx1));

  assign bus.wr0    = wr0_q;
  assign bus.wr1    = wr1_q;
  assign bus.waddr0 = waddr0_q;
  assign bus.waddr1 = waddr1_q;
  assign bus.wd0    = wd0_q;
  assign bus.wd1    = wd1_q;
  assign idle       = (state_q == StIdle);
  assign wr_cnt     = wr_cnt_q;

  // Hazard compare only looks at the register-file index bits.
  logic unused_chk;
  assign unused_chk = ^{bus.chk_addr0[AW-1:IDX_W], bus.chk_addr1[AW-1:IDX_W]};

endmodule
